// File: rtl/video_timing_controller.sv
// Raster sequencer for the HDMI TMDS path: generates h/v timing, DE and syncs,
// and pulls RGB888 pixels from upstream with a ready/valid handshake.
module video_timing_controller #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic        underflow_clr,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        frame_start,
  output logic        underflow,
  output logic [11:0] hcount,
  output logic [10:0] vcount
);

  // H_TOTAL must not exceed 4096 and V_TOTAL must not exceed 2048 so the
  // counters below cover the full raster.
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  localparam logic HS_ON  = 1'(HS_POL);
  localparam logic VS_ON  = 1'(VS_POL);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t      state;
  logic [11:0] h;
  logic [10:0] v;

  logic run;
  logic active;
  logic hs_raw;
  logic vs_raw;
  logic h_last;
  logic v_last;

  // Counters are compared as int so parameter arithmetic never truncates.
  always_comb begin
    run    = (state == RUN);
    h_last = (int'(h) == H_TOTAL - 1);
    v_last = (int'(v) == V_TOTAL - 1);
    active = run && (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
    hs_raw = run && (int'(h) >= HS_START) && (int'(h) < HS_END);
    vs_raw = run && (int'(v) >= VS_START) && (int'(v) < VS_END);
  end

  assign pix_ready = active;

  // NOTE: every register here is updated with non-blocking assignments so all
  // outputs sample the same pre-edge counter values and stay mutually aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      h           <= '0;
      v           <= '0;
      de          <= 1'b0;
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
      hcount      <= '0;
      vcount      <= '0;
    end else begin
      case (state)
        IDLE: begin
          h <= '0;
          v <= '0;
          if (enable) state <= RUN;
        end
        RUN: begin
          if (h_last) begin
            h <= '0;
            if (v_last) begin
              v <= '0;
              // enable only matters at the frame boundary: frames never truncate.
              if (!enable) state <= IDLE;
            end else begin
              v <= v + 11'd1;
            end
          end else begin
            h <= h + 12'd1;
          end
        end
        default: state <= IDLE;
      endcase

      de          <= active;
      hsync       <= hs_raw ? HS_ON : ~HS_ON;
      vsync       <= vs_raw ? VS_ON : ~VS_ON;
      frame_start <= run && (h == '0) && (v == '0);
      hcount      <= h;
      vcount      <= v;

      // A starved active pixel goes out black; the raster itself never stalls.
      if (active && pix_valid) begin
        red   <= pix_data[23:16];
        green <= pix_data[15:8];
        blue  <= pix_data[7:0];
      end else begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end

      // Set has priority so a clear cannot hide an underflow in the same cycle.
      if (active && !pix_valid) underflow <= 1'b1;
      else if (underflow_clr)   underflow <= 1'b0;
    end
  end

endmodule

// File: doc/video_timing_controller.md
# video_timing_controller

Pixel-clock sequencer that drives the three TMDS encoder channels of the HDMI output path. It generates the horizontal and vertical raster, DE, HSYNC and VSYNC, and pulls RGB888 pixels from the upstream frame/line buffer with a ready/valid handshake. It presents registered, mutually aligned data and control to the per-channel encoders:

- `red` → channel 2 D
- `green` → channel 1 D
- `blue` → channel 0 D
- `hsync` → channel 0 C0
- `vsync` → channel 0 C1
- `de` → DE on all three channels

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level

Ports:
- clk  in  1  pixel clock; the only clock
- rst  in  1  reset, synchronous, active-high
- enable  in  1  request raster output
- pix_data  in  24  {R[23:16], G[15:8], B[7:0]} from upstream
- pix_valid  in  1  pix_data valid
- pix_ready  out  1  controller consumes pix_data this cycle
- underflow_clr  in  1  clears underflow
- de  out  1  data enable to encoders
- hsync  out  1  to channel 0 C0
- vsync  out  1  to channel 0 C1
- red, green, blue  out  8 each  encoder D inputs
- frame_start  out  1  one-cycle pulse aligned with pixel (0,0) on the outputs
- underflow  out  1  sticky: an active pixel found pix_valid low
- hcount  out  12  registered h position of the current outputs
- vcount  out  11  registered v position of the current outputs

## Operation
Derived totals:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; must be ≤ 4096.
- V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; must be ≤ 2048.

Internal counters h in 0..H_TOTAL-1 and v in 0..V_TOTAL-1:
- Line order: active, front porch, sync, back porch.
- h wraps to 0 after H_TOTAL-1; v increments at that wrap and wraps to 0 after V_TOTAL-1.

State machine, two states:
- **IDLE**
  - h and v held at 0.
  - pix_ready = 0.
  - Outputs held in blanking: de = 0, hsync = ~HS_POL, vsync = ~VS_POL, rgb = 0.
  - Moves to RUN on the clock edge where enable = 1.
- **RUN**
  - Counters advance every cycle.
  - enable is sampled only at (h = H_TOTAL-1, v = V_TOTAL-1). If it is 0 there, the next state is IDLE; otherwise the raster continues.
  - Dropping enable mid-frame always completes the current frame.

Raster signals:
- Combinational active = RUN & h < H_ACTIVE & v < V_ACTIVE.
- pix_ready = active. pix_ready is a pure function of state and counters and is independent of pix_valid.
- A pixel transfers when pix_ready & pix_valid.
- hs_raw = H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC.
- vs_raw = V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC. vsync spans whole lines, with edges coincident with h = 0.

Registered outputs, updated each edge from the current counters:
- de ← active.
- hsync ← hs_raw ? HS_POL : ~HS_POL.
- vsync ← vs_raw ? VS_POL : ~VS_POL.
- rgb ← (active & pix_valid) ? pix_data : 0.
- frame_start ← RUN & h = 0 & v = 0.
- hcount/vcount ← h/v.

Underflow:
- Condition: active & ~pix_valid. The pixel outputs black (rgb = 0), de remains 1, and the raster never stalls.
- underflow is set by that condition and cleared by underflow_clr.
- If set and clear occur in the same cycle, set wins.

Reset:
- Counters go to 0 and state to IDLE.
- Outputs take their reset values: de = 0, hsync = ~HS_POL, vsync = ~VS_POL, rgb = 0, frame_start = 0, underflow = 0, hcount = vcount = 0.
- pix_ready = 0.
- Reset mid-frame abandons the frame immediately. No partial-frame completion.

## Timing
- Latency is 1 cycle from counter position to de/hsync/vsync/rgb/frame_start/hcount. The TMDS encoder adds 1 more, so q_out lags the counters by 2 cycles. All three channels see identical latency.
- IDLE→RUN: enable high at edge N gives counters (0,0) in cycle N+1, pix_ready high in cycle N+1, and de/frame_start high in cycle N+2.
- pix_ready deasserts in the same cycle h reaches H_ACTIVE. Upstream must not rely on ready back-pressure timing beyond this rule.
- Back-to-back frames: frame_start pulses exactly every H_TOTAL·V_TOTAL cycles.
- RUN→IDLE: the last RUN output cycle shows position (H_TOTAL-1, V_TOTAL-1). The next output cycle shows blanking levels, with no frame_start.

## Test plan
Tests use the small raster H_ACTIVE = 4, H_FP = 1, H_SYNC = 2, H_BP = 1 (H_TOTAL = 8) and V_ACTIVE = 3, V_FP = 1, V_SYNC = 1, V_BP = 1 (V_TOTAL = 6), with polarities 0.

1. **Startup:** rst for 2 cycles, then enable = 1, pix_valid = 1, incrementing pix_data → frame_start and first de occur 2 cycles after enable rises. de is high for 4 cycles per 8-cycle line on lines 0–2. rgb equals the accepted data in order (12 pixels/frame).
2. **Horizontal sync:** → hsync is 0 exactly while hcount = 5, 6 on every line, including blanking lines. de = 0 for hcount 4–7.
3. **Vertical sync:** vsync is 0 for the 8 outputs with vcount = 4 only → repeat with VS_POL = 1: vsync is 1 during those outputs and 0 elsewhere.
4. **Underflow:** pix_valid = 0 at pixel (2,1) → rgb = 0, de = 1, underflow = 1 from the next cycle. underflow_clr asserted together with a new underflow at (3,2) → underflow stays 1. Clear with no underflow → 0.
5. **Enable drop:** enable dropped at output cycle 10 of a frame → the frame completes all 48 cycles, then de = 0, hsync = vsync = 1, no further frame_start. Re-assert enable → frame_start occurs 2 cycles later.
6. **Reset mid-operation:** rst at pixel (2,1) → the next output cycle has de = 0, hsync = vsync = 1, rgb = 0, hcount = vcount = 0, underflow = 0, pix_ready = 0, and the block is in IDLE.
